change_dispenser: RTL and testbench

- Returns change after a purchase completes.
- Takes the over-payment amount and drives a coin hopper one coin at a time over a four-phase req/ack handshake, using denominations 10, 5 and 2.
- Sits beside the vending FSM, which pulses start with the change amount on the dispense step.
- Exposes the remaining balance so the existing binary-to-BCD/seven-segment path can show it.

---
 rtl/change_dispenser_pkg.sv | 30 +++
 rtl/change_dispenser_coin_select.sv | 53 +++++
 rtl/change_dispenser.sv | 154 +++++++++++++++
 tb/tb_change_dispenser.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared definitions for the change dispenser: coin denomination codes and
//   their dollar values, the dispenser state encoding and the denom typedef.
//   The $1 coin (DENOM_1) is only driven when CHANGE_ONE_COIN_EN is defined.
package change_dispenser_pkg;

    // Denomination code as seen on coin_denom.
    typedef enum logic [1:0] {
        DENOM_1  = 2'd0,
        DENOM_2  = 2'd1,
        DENOM_5  = 2'd2,
        DENOM_10 = 2'd3
    } denom_t;

    // Dollar value of each denomination.
    localparam int VAL_1  = 1;
    localparam int VAL_2  = 2;
    localparam int VAL_5  = 5;
    localparam int VAL_10 = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        REQ     = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4,
        FAULT   = 3'd5
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// coin_select
//   Combinational choice of the next coin for a remaining balance.
//   Build option: CHANGE_ONE_COIN_EN adds the $1 coin and switches to plain
//   greedy selection; otherwise balances of 1 or 3 are left as residual.
// Ports:
//   r      in   AMT_W  remaining balance
//   valid  out  1      a coin should be dispensed
//   code   out  2      denomination code of that coin
//   value  out  AMT_W  dollar value of that coin
module coin_select
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] r,
    output logic             valid,
    output denom_t           code,
    output logic [AMT_W-1:0] value
);

    localparam logic [AMT_W-1:0] V1  = AMT_W'(VAL_1);
    localparam logic [AMT_W-1:0] V2  = AMT_W'(VAL_2);
    localparam logic [AMT_W-1:0] V5  = AMT_W'(VAL_5);
    localparam logic [AMT_W-1:0] V10 = AMT_W'(VAL_10);

    always_comb begin
        valid = 1'b0;
        code  = DENOM_2;
        value = '0;
`ifdef CHANGE_ONE_COIN_EN
        if (r >= V10) begin
            valid = 1'b1; code = DENOM_10; value = V10;
        end else if (r >= V5) begin
            valid = 1'b1; code = DENOM_5;  value = V5;
        end else if (r >= V2) begin
            valid = 1'b1; code = DENOM_2;  value = V2;
        end else if (r == V1) begin
            valid = 1'b1; code = DENOM_1;  value = V1;
        end
`else
        // Without a $1 coin, 11 and 13 must not take a $10 (1 and 3 cannot be
        // paid from $5/$2), and $5 is only used to make an odd balance even.
        if (r >= V10 && r != AMT_W'(11) && r != AMT_W'(13)) begin
            valid = 1'b1; code = DENOM_10; value = V10;
        end else if (r >= V5 && r[0]) begin
            valid = 1'b1; code = DENOM_5;  value = V5;
        end else if (r >= V2 && r != AMT_W'(3)) begin
            valid = 1'b1; code = DENOM_2;  value = V2;
        end
`endif
    end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Returns change after a purchase: dispenses coins ($10/$5/$2, plus $1 when
//   CHANGE_ONE_COIN_EN is defined) one at a time over a four-phase req/ack
//   handshake with the hopper, exposing the balance still to be paid.
// Ports:
//   clk         in   1      system clock
//   reset       in   1      asynchronous active-low reset
//   start       in   1      one-cycle request, sampled only in IDLE
//   change_amt  in   AMT_W  amount to return in dollars
//   coin_req    out  1      hopper request
//   coin_denom  out  2      denomination code (0=$1, 1=$2, 2=$5, 3=$10)
//   coin_ack    in   1      hopper acknowledge (asynchronous, 2-flop synced)
//   busy        out  1      dispense in progress
//   done        out  1      one-cycle pulse at end of dispensing
//   fault       out  1      handshake timeout, sticky until reset
//   remaining   out  AMT_W  balance not yet dispensed
//   coins_out   out  AMT_W  coins dispensed since start (saturating)
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int TO_W        = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    output logic             coin_req,
    output logic [1:0]       coin_denom,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coins_out
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t           state;
    logic             ack_s1;
    logic             ack_s2;
    logic [TO_W-1:0]  to_cnt;

    logic             sel_valid;
    denom_t           sel_code;
    logic [AMT_W-1:0] sel_value;
    logic [AMT_W-1:0] coin_value;   // value of the coin in flight

    coin_select #(.AMT_W(AMT_W)) u_coin_select (
        .r     (remaining),
        .valid (sel_valid),
        .code  (sel_code),
        .value (sel_value)
    );

    // The timeout counter reaching its last value means this handshake phase
    // has used up all ACK_TIMEOUT cycles.
    logic timed_out;
    assign timed_out = (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= coin_ack;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            coin_req   <= 1'b0;
            coin_denom <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            remaining  <= '0;
            coins_out  <= '0;
            coin_value <= '0;
            to_cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_amt;
                        coins_out <= '0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (sel_valid) begin
                        coin_denom <= sel_code;
                        coin_value <= sel_value;
                        coin_req   <= 1'b1;
                        to_cnt     <= '0;
                        state      <= REQ;
                    end else begin
                        // Residual balance stays visible in remaining.
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                REQ: begin
                    if (ack_s2) begin
                        coin_req  <= 1'b0;
                        remaining <= remaining - coin_value;
                        if (coins_out != '1) begin
                            coins_out <= coins_out + 1'b1;
                        end
                        to_cnt    <= '0;
                        state     <= RELEASE;
                    end else if (timed_out) begin
                        coin_req <= 1'b0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s2) begin
                        state <= SELECT;
                    end else if (timed_out) begin
                        busy  <= 1'b0;
                        fault <= 1'b1;
                        state <= FAULT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    coin_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//   Randomised and directed stimulus for change_dispenser with a scoreboard:
//   the stimulus pushes expected coin codes and end-of-dispense results, a
//   monitor pops and compares them as the DUT raises coin_req or done.
module tb_change_dispenser;

    localparam int AMT_W       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int TO_W        = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [AMT_W-1:0] change_amt = '0;
    logic             coin_req;
    logic [1:0]       coin_denom;
    logic             coin_ack = 1'b0;
    logic             busy;
    logic             done;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] coins_out;

    change_dispenser #(
        .AMT_W(AMT_W), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
        .coin_req(coin_req), .coin_denom(coin_denom), .coin_ack(coin_ack),
        .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .coins_out(coins_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_coin_q[$];
    int exp_rem_q[$];
    int exp_cnt_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: walk the balance down coin by coin using the
    // denomination rules and queue every expected coin plus the end result.
    task automatic push_expect(input int amt, output int ncoins);
        int r;
        int v;
        r = amt;
        ncoins = 0;
        while (1) begin
`ifdef CHANGE_ONE_COIN_EN
            if (r >= 10)      v = 10;
            else if (r >= 5)  v = 5;
            else if (r >= 2)  v = 2;
            else if (r == 1)  v = 1;
            else              v = 0;
`else
            if (r >= 10 && r != 11 && r != 13) v = 10;
            else if (r >= 5 && (r % 2) == 1)   v = 5;
            else if (r >= 2 && r != 3)         v = 2;
            else                               v = 0;
`endif
            if (v == 0) break;
            exp_coin_q.push_back(v == 10 ? 3 : v == 5 ? 2 : v == 2 ? 1 : 0);
            r -= v;
            ncoins++;
        end
        exp_rem_q.push_back(r);
        exp_cnt_q.push_back(ncoins);
    endtask

    // Hopper: follows coin_req with a random delay of 0..3 cycles per edge.
    bit hop_en = 1'b1;
    int hop_wait = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!hop_en) begin
                coin_ack = 1'b0;
            end else if (coin_req != coin_ack) begin
                if (hop_wait == 0) begin
                    coin_ack = coin_req;
                    hop_wait = $urandom_range(0, 3);
                end else begin
                    hop_wait--;
                end
            end
        end
    end

    // Monitor / scoreboard.
    logic prev_req  = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (coin_req && !prev_req) begin
                if (exp_coin_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_coin: got denom %0d, expected no coin", coin_denom);
                end else begin
                    check("coin_denom", int'(coin_denom), exp_coin_q.pop_front());
                    check("busy_during_coin", int'(busy), 1);
                end
            end
            if (done) begin
                check("done_one_cycle", int'(prev_done), 0);
                if (exp_rem_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no done");
                end else begin
                    check("remaining_at_done", int'(remaining), exp_rem_q.pop_front());
                    check("coins_out_at_done", int'(coins_out), exp_cnt_q.pop_front());
                    check("coins_all_issued", exp_coin_q.size(), 0);
                end
            end
        end
        prev_req  <= coin_req;
        prev_done <= done;
    end

    // Called on a negedge; returns one negedge later with start low again.
    task automatic issue(input int amt, output int ncoins);
        push_expect(amt, ncoins);
        start = 1'b1;
        change_amt = AMT_W'(amt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full dispense; poke>0 pulses start with 99 at that cycle offset.
    task automatic run(input int amt, input int poke);
        int ncoins, lat, first_req, done_lat;
        bit seen;
        issue(amt, ncoins);
        lat = 1; first_req = -1; done_lat = -1; seen = 0;
        while (!seen && lat < 4000) begin
            if (coin_req && first_req < 0) first_req = lat;
            if (done) begin
                seen = 1;
                done_lat = lat;
            end else begin
                if (lat == poke) begin
                    start = 1'b1;
                    change_amt = AMT_W'(99);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
        if (ncoins > 0) begin
            check("req_latency", first_req, 2);
        end else begin
            check("done_latency", done_lat, 2);
            check("no_coin_req", first_req, -1);
        end
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_coin_req"},   int'(coin_req), 0);
        check({tag, "_coin_denom"}, int'(coin_denom), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_done"},       int'(done), 0);
        check({tag, "_fault"},      int'(fault), 0);
        check({tag, "_remaining"},  int'(remaining), 0);
        check({tag, "_coins_out"},  int'(coins_out), 0);
    endtask

    initial begin
        int n, cyc, t_req;
        bit got;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed amounts, including the no-coin cases 0, 1 and 3.
        run(18, 0);
        run(11, 0);
        run(3, 0);
        run(0, 0);
        run(1, 0);
        run(13, 0);
        run(255, 0);
        // start while busy must be ignored.
        run(40, 6);

        // Randomised amounts.
        for (int i = 0; i < 25; i++) begin
            run($urandom_range(0, 120), (i % 4 == 0) ? int'($urandom_range(3, 12)) : 0);
        end

        // Reset while a coin request is outstanding.
        issue(20, n);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (coin_req) got = 1;
            else @(negedge clk);
        end
        check("reset_test_req_seen", int'(got), 1);
        #2 reset = 1'b0;
        #1 check_reset_values("async_reset");
        exp_coin_q.delete();
        exp_rem_q.delete();
        exp_cnt_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        run(10, 0);

        // Hopper never acknowledges: timeout into FAULT.
        hop_en = 1'b0;
        repeat (2) @(negedge clk);
        exp_coin_q.push_back(2);
        start = 1'b1;
        change_amt = AMT_W'(7);
        @(negedge clk);
        start = 1'b0;
        t_req = -1;
        cyc = 0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (coin_req && t_req < 0) t_req = cyc;
            if (fault) got = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("fault_seen", int'(got), 1);
        check("fault_cycles_in_req", cyc - t_req, ACK_TIMEOUT);
        check("fault_coin_req", int'(coin_req), 0);
        check("fault_busy", int'(busy), 0);
        start = 1'b1;
        change_amt = AMT_W'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("fault_start_ignored_busy", int'(busy), 0);
        check("fault_start_ignored_req", int'(coin_req), 0);
        check("fault_sticky", int'(fault), 1);

        check("coin_queue_empty", exp_coin_q.size(), 0);
        check("done_queue_empty", exp_rem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
